mem_port_arbiter: RTL and testbench

- Sits between the mp3 core's two 16-bit memory ports and a single 128-bit-line physical memory.
- Port a is instruction fetch; port b is data load/store.
- Arbitrates between the two ports and splits each 128-bit line into 16-bit words.
- Performs read-modify-write so the core keeps its word/byte-enable interface.

---
 rtl/mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Connects the core's two 16-bit memory ports (a = instruction fetch,
//   b = data load/store) to one wide-line physical memory. Requests are
//   arbitrated in IDLE with alternating priority, each line is split into
//   16-bit words, and sub-line writes are done as read-modify-write.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   mem_read_x / mem_write_x        port x request (write wins if both set)
//   mem_byte_enable_x               port x byte mask, bit0 = low byte
//   mem_address_x / mem_wdata_x     port x byte address (bit0 ignored) / data
//   mem_resp_x / mem_rdata_x        one-cycle completion pulse / read data
//   pmem_read / pmem_write          physical requests, held until pmem_resp
//   pmem_address / pmem_wdata       line-aligned address / line write data
//   pmem_resp / pmem_rdata          physical completion pulse / line data
//
// Build option
//   MEM_ARB_LINE_BUF_EN  adds a one-line read buffer; a read whose line tag
//                        matches a valid buffer entry completes without any
//                        physical access.

module mem_port_arbiter #(
  parameter int unsigned LINE_BITS = 128,
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_read_a,
  input  logic                 mem_write_a,
  input  logic [1:0]           mem_byte_enable_a,
  input  logic [ADDR_BITS-1:0] mem_address_a,
  input  logic [15:0]          mem_wdata_a,
  output logic                 mem_resp_a,
  output logic [15:0]          mem_rdata_a,
  input  logic                 mem_read_b,
  input  logic                 mem_write_b,
  input  logic [1:0]           mem_byte_enable_b,
  input  logic [ADDR_BITS-1:0] mem_address_b,
  input  logic [15:0]          mem_wdata_b,
  output logic                 mem_resp_b,
  output logic [15:0]          mem_rdata_b,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [ADDR_BITS-1:0] pmem_address,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic                 pmem_resp,
  input  logic [LINE_BITS-1:0] pmem_rdata
);

  localparam int unsigned OFF  = $clog2(LINE_BITS / 8);
  localparam int unsigned WIDX = OFF - 1;
  localparam int unsigned TAGW = ADDR_BITS - OFF;

  typedef enum logic [2:0] {IDLE, FETCH, MERGE, STORE, RESP} state_t;

  state_t                 state;
  logic                   last_b;
  logic                   gnt_b_q;
  logic                   wr_q;
  logic [1:0]             mask_q;
  logic [ADDR_BITS-1:1]   addr_q;
  logic [15:0]            wdata_q;
  logic [LINE_BITS-1:0]   line_q;

  logic                   req_a;
  logic                   req_b;
  logic                   pick_b;
  logic                   sel_wr;
  logic [1:0]             sel_mask;
  logic [ADDR_BITS-1:1]   sel_addr;
  logic [15:0]            sel_wdata;
  logic [TAGW-1:0]        sel_tag;
  logic [WIDX-1:0]        q_widx;
  logic [LINE_BITS-1:0]   merged;
  logic [15:0]            fetch_word;
  logic                   hit;
  logic [15:0]            hit_word;

  // Byte address bit 0 carries no information for 16-bit words.
  logic addr_lsb_unused;
  assign addr_lsb_unused = mem_address_a[0] ^ mem_address_b[0];

  assign req_a = mem_read_a | mem_write_a;
  assign req_b = mem_read_b | mem_write_b;
  // last_b=0 means a was granted last, so b wins a tie.
  assign pick_b = req_b & (~req_a | ~last_b);

  assign sel_wr    = pick_b ? mem_write_b : mem_write_a;
  assign sel_mask  = pick_b ? mem_byte_enable_b : mem_byte_enable_a;
  assign sel_addr  = pick_b ? mem_address_b[ADDR_BITS-1:1] : mem_address_a[ADDR_BITS-1:1];
  assign sel_wdata = pick_b ? mem_wdata_b : mem_wdata_a;
  assign sel_tag   = sel_addr[ADDR_BITS-1:OFF];

  assign q_widx     = addr_q[OFF-1:1];
  assign fetch_word = pmem_rdata[{q_widx, 4'b0000} +: 16];

  always_comb begin
    merged = line_q;
    if (mask_q[0]) merged[{q_widx, 4'b0000} +: 8] = wdata_q[7:0];
    if (mask_q[1]) merged[{q_widx, 4'b1000} +: 8] = wdata_q[15:8];
  end

`ifdef MEM_ARB_LINE_BUF_EN
  logic                 buf_valid;
  logic [TAGW-1:0]      buf_tag;
  logic [LINE_BITS-1:0] buf_data;
  logic [WIDX-1:0]      sel_widx;

  assign sel_widx = sel_addr[OFF-1:1];
  assign hit      = buf_valid && (buf_tag == sel_tag);
  assign hit_word = buf_data[{sel_widx, 4'b0000} +: 16];

  // Buffer tracks the last line seen on the physical side; line_q holds
  // the merged line throughout STORE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == FETCH && pmem_resp) begin
      buf_valid <= 1'b1;
      buf_tag   <= addr_q[ADDR_BITS-1:OFF];
      buf_data  <= pmem_rdata;
    end else if (state == STORE && pmem_resp) begin
      buf_valid <= 1'b1;
      buf_tag   <= addr_q[ADDR_BITS-1:OFF];
      buf_data  <= line_q;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_word = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_b       <= 1'b0;
      gnt_b_q      <= 1'b0;
      wr_q         <= 1'b0;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      line_q       <= '0;
      mem_resp_a   <= 1'b0;
      mem_resp_b   <= 1'b0;
      mem_rdata_a  <= '0;
      mem_rdata_b  <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            gnt_b_q      <= pick_b;
            last_b       <= pick_b;
            wr_q         <= sel_wr;
            mask_q       <= sel_mask;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            pmem_address <= {sel_tag, {OFF{1'b0}}};
            if ((sel_wr && sel_mask == 2'b00) || (!sel_wr && hit)) begin
              state <= RESP;
              if (pick_b) begin
                mem_resp_b  <= 1'b1;
                mem_rdata_b <= sel_wr ? 16'h0000 : hit_word;
              end else begin
                mem_resp_a  <= 1'b1;
                mem_rdata_a <= sel_wr ? 16'h0000 : hit_word;
              end
            end else begin
              state     <= FETCH;
              pmem_read <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (pmem_resp) begin
            pmem_read <= 1'b0;
            line_q    <= pmem_rdata;
            if (wr_q) begin
              state <= MERGE;
            end else begin
              state <= RESP;
              if (gnt_b_q) begin
                mem_resp_b  <= 1'b1;
                mem_rdata_b <= fetch_word;
              end else begin
                mem_resp_a  <= 1'b1;
                mem_rdata_a <= fetch_word;
              end
            end
          end
        end
        MERGE: begin
          line_q     <= merged;
          pmem_wdata <= merged;
          pmem_write <= 1'b1;
          state      <= STORE;
        end
        STORE: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            state      <= RESP;
            if (gnt_b_q) mem_resp_b <= 1'b1;
            else         mem_resp_a <= 1'b1;
          end
        end
        RESP: begin
          mem_resp_a  <= 1'b0;
          mem_resp_b  <= 1'b0;
          mem_rdata_a <= '0;
          mem_rdata_b <= '0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a physical memory model with
// fixed latency, a scoreboard of expected port responses, and directed
// sequences for reads, RMW writes, no-op writes, reset abort, arbitration
// fairness and (optionally) the line buffer.

module tb_mem_port_arbiter;

  localparam int unsigned MEM_LAT = 2;
  // Cycles from a physical request becoming visible to the DUT capture edge.
  localparam int unsigned P = MEM_LAT + 1;
`ifdef MEM_ARB_LINE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         mem_read_a, mem_write_a, mem_read_b, mem_write_b;
  logic [1:0]   mem_byte_enable_a, mem_byte_enable_b;
  logic [15:0]  mem_address_a, mem_address_b, mem_wdata_a, mem_wdata_b;
  logic         mem_resp_a, mem_resp_b;
  logic [15:0]  mem_rdata_a, mem_rdata_b;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;

  mem_port_arbiter #(.LINE_BITS(128), .ADDR_BITS(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_a(mem_read_a), .mem_write_a(mem_write_a),
    .mem_byte_enable_a(mem_byte_enable_a), .mem_address_a(mem_address_a),
    .mem_wdata_a(mem_wdata_a), .mem_resp_a(mem_resp_a), .mem_rdata_a(mem_rdata_a),
    .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_byte_enable_b(mem_byte_enable_b), .mem_address_b(mem_address_b),
    .mem_wdata_b(mem_wdata_b), .mem_resp_b(mem_resp_b), .mem_rdata_b(mem_rdata_b),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [15:0] init_word(input int unsigned ln, input int unsigned i);
    if (ln == 1 && i == 5) return 16'h5555;
    return 16'(16'h1110 + ln * 16 + i);
  endfunction

  function automatic logic [127:0] init_line(input int unsigned ln);
    logic [127:0] l;
    for (int unsigned i = 0; i < 8; i++) l[16*i +: 16] = init_word(ln, i);
    return l;
  endfunction

  // Physical memory model: responds MEM_LAT cycles after seeing a request.
  logic [127:0] mem [0:255];
  bit           mem_init = 1'b0;
  int unsigned  mcnt = 0;
  int unsigned  rd_cnt = 0, wr_cnt = 0;
  logic [15:0]  last_paddr = '0;
  int unsigned  cyc = 0;

  initial begin
    pmem_rdata = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!mem_init) begin
      for (int unsigned ln = 0; ln < 256; ln++) mem[ln] <= init_line(ln);
      mem_init <= 1'b1;
    end
    if (!rst_n) begin
      mcnt      <= 0;
      pmem_resp <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      if ((pmem_read || pmem_write) && !pmem_resp) begin
        if (mcnt == MEM_LAT - 1) begin
          mcnt       <= 0;
          pmem_resp  <= 1'b1;
          last_paddr <= pmem_address;
          if (pmem_write) begin
            mem[pmem_address[11:4]] <= pmem_wdata;
            wr_cnt <= wr_cnt + 1;
          end else begin
            pmem_rdata <= mem[pmem_address[11:4]];
            rd_cnt <= rd_cnt + 1;
          end
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard and protocol monitor.
  typedef struct {
    bit          port_b;
    bit          rd;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  int unsigned resp_cnt = 0, both_pm = 0, both_resp = 0, dbl = 0;
  bit prev_a = 1'b0, prev_b = 1'b0;

  always @(negedge clk) begin
    if (pmem_read && pmem_write) both_pm++;
    if (rst_n) begin
      if ((mem_resp_a && prev_a) || (mem_resp_b && prev_b)) dbl++;
      if (mem_resp_a || mem_resp_b) begin
        exp_t e;
        resp_cnt++;
        if (mem_resp_a && mem_resp_b) both_resp++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
        end else begin
          e.port_b = ~mem_resp_b;
          e.rd     = 1'b0;
          e.data   = '0;
        end
        check("resp_port", mem_resp_b, e.port_b);
        if (e.rd) check("rdata", mem_resp_b ? mem_rdata_b : mem_rdata_a, e.data);
        check("other_rdata", mem_resp_b ? mem_rdata_a : mem_rdata_b, 16'h0000);
      end
    end
    prev_a = mem_resp_a;
    prev_b = mem_resp_b;
  end

  task automatic drive_port(input bit pb, input bit rd, input bit wr, input logic [1:0] mask,
                            input logic [15:0] addr, input logic [15:0] wd);
    if (pb) begin
      mem_read_b = rd; mem_write_b = wr; mem_byte_enable_b = mask;
      mem_address_b = addr; mem_wdata_b = wd;
    end else begin
      mem_read_a = rd; mem_write_a = wr; mem_byte_enable_a = mask;
      mem_address_a = addr; mem_wdata_a = wd;
    end
  endtask

  // Called at posedge+1; lat = cycles from grant edge to the edge ending the pulse.
  task automatic issue(input bit pb, input bit wr, input logic [1:0] mask, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd, output int unsigned lat);
    exp_t e;
    bit got;
    int unsigned t0;
    e.port_b = pb; e.rd = !wr; e.data = exp_rd;
    sb.push_back(e);
    t0 = cyc;
    drive_port(pb, !wr, wr, mask, addr, wd);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (pb ? mem_resp_b : mem_resp_a) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    check("resp_timeout", got, 1'b1);
    @(posedge clk); #1;
    drive_port(pb, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int unsigned lat, r0, w0, base;
    bit got;
    logic [127:0] exp_line;

    rst_n = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drive_port(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_a", mem_resp_a, 1'b0);
    check("rst_resp_b", mem_resp_b, 1'b0);
    check("rst_rdata_a", mem_rdata_a, 16'h0000);
    check("rst_rdata_b", mem_rdata_b, 16'h0000);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_addr", pmem_address, 16'h0000);
    check("rst_pmem_wdata", pmem_wdata, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Port a read of word 3 in line 0.
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b0, 1'b0, 2'b11, 16'h0006, 16'h0000, 16'h1113, lat);
    check("rd_a_pmem_reads", rd_cnt - r0, 1);
    check("rd_a_pmem_writes", wr_cnt - w0, 0);
    check("rd_a_paddr", last_paddr, 16'h0000);
    check("rd_a_latency", lat, P + 1);

    // Port b low-byte write into word 5 of line 0x0010.
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b1, 1'b1, 2'b01, 16'h001A, 16'hABCD, 16'h0000, lat);
    exp_line = init_line(1);
    exp_line[80 +: 16] = 16'h55CD;
    check("wr_b_line", mem[1], exp_line);
    check("wr_b_pmem_reads", rd_cnt - r0, 1);
    check("wr_b_pmem_writes", wr_cnt - w0, 1);
    check("wr_b_paddr", last_paddr, 16'h0010);
    check("wr_b_latency", lat, 2 * P + 2);

    // Empty mask: no physical traffic, RESP follows the grant edge directly.
    r0 = rd_cnt; w0 = wr_cnt;
    issue(1'b0, 1'b1, 2'b00, 16'h0020, 16'hFFFF, 16'h0000, lat);
    check("noop_pmem_reads", rd_cnt - r0, 0);
    check("noop_pmem_writes", wr_cnt - w0, 0);
    check("noop_latency", lat, 1);
    check("noop_line", mem[2], init_line(2));

    // Reset while the write is in STORE.
    w0 = wr_cnt; base = resp_cnt;
    drive_port(1'b0, 1'b0, 1'b1, 2'b11, 16'h0032, 16'h1234);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (pmem_write) got = 1'b1;
    end
    check("store_reached", got, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pmem_write", pmem_write, 1'b0);
    check("abort_pmem_read", pmem_read, 1'b0);
    check("abort_resp_a", mem_resp_a, 1'b0);
    check("abort_resp_b", mem_resp_b, 1'b0);
    drive_port(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    check("abort_line", mem[3], init_line(3));
    check("abort_writes", wr_cnt - w0, 0);
    check("abort_no_resp", resp_cnt - base, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 2'b11, 16'h0034, 16'h0000, init_word(3, 2), lat);
    check("post_rst_latency", lat, P + 1);

    // Both ports reading continuously; b was granted last, so a goes first.
    base = resp_cnt;
    sb.push_back('{1'b0, 1'b1, 16'h1113});
    sb.push_back('{1'b1, 1'b1, init_word(2, 2)});
    sb.push_back('{1'b0, 1'b1, 16'h1113});
    sb.push_back('{1'b1, 1'b1, init_word(2, 2)});
    drive_port(1'b0, 1'b1, 1'b0, 2'b11, 16'h0006, 16'h0000);
    drive_port(1'b1, 1'b1, 1'b0, 2'b11, 16'h0024, 16'h0000);
    for (int i = 0; i < 400 && resp_cnt < base + 4; i++) begin
      @(negedge clk); #1;
    end
    check("alt_resp_count", resp_cnt - base, 4);
    @(posedge clk); #1;
    drive_port(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    drive_port(1'b1, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    check("alt_no_extra", resp_cnt - base, 4);

    // Repeated read of one line, then write + read of the same line.
    r0 = rd_cnt;
    issue(1'b0, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1150, lat);
    issue(1'b0, 1'b0, 2'b11, 16'h0040, 16'h0000, 16'h1150, lat);
    check("reread_pmem_reads", rd_cnt - r0, BUF_EN ? 1 : 2);
    check("reread_latency", lat, BUF_EN ? 1 : P + 1);
    issue(1'b1, 1'b1, 2'b11, 16'h0042, 16'hBEEF, 16'h0000, lat);
    r0 = rd_cnt;
    issue(1'b0, 1'b0, 2'b11, 16'h0042, 16'h0000, 16'hBEEF, lat);
    check("rd_after_wr_reads", rd_cnt - r0, BUF_EN ? 0 : 1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("pmem_rd_wr_overlap", both_pm, 0);
    check("resp_both_ports", both_resp, 0);
    check("resp_multi_cycle", dbl, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
